// File: rtl/flex_counter_ud_if.sv
// Control and status bundle for flex_counter_ud.
// master drives the controls and observes the count; slave is the counter itself.
interface flex_counter_ud_if #(
  parameter int SIZE   = 8,
  parameter int STEP_W = 4
);
  logic              clear;
  logic              load;
  logic [SIZE-1:0]   load_val;
  logic              count_enable;
  logic              count_down;
  logic [STEP_W-1:0] step;
  logic [SIZE-1:0]   rollover_val;
  logic              saturate;
  logic [SIZE-1:0]   count_out;
  logic              rollover_flag;
  logic              rollover_pulse;

  // Level controls only, no handshake: every input is sampled on every rising
  // clock edge and every output is a register that changes on that same edge.
  modport master (
    output clear, load, load_val, count_enable, count_down, step,
           rollover_val, saturate,
    input  count_out, rollover_flag, rollover_pulse
  );

  modport slave (
    input  clear, load, load_val, count_enable, count_down, step,
           rollover_val, saturate,
    output count_out, rollover_flag, rollover_pulse
  );
endinterface

// File: rtl/flex_counter_ud.sv
// Programmable up/down counter over 1..max(rollover_val,1) with step, load and wrap pulse.
// Define FLEX_COUNTER_UD_SATURATE_EN to honour the saturate input; otherwise it always wraps.
module flex_counter_ud #(
  parameter int SIZE   = 8,
  parameter int STEP_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  flex_counter_ud_if.slave      bus
);

  // Wide enough that count + step can never overflow silently.
  localparam int W = ((STEP_W > SIZE) ? STEP_W : SIZE) + 1;

  logic [SIZE-1:0] count_q;
  logic            flag_q;
  logic            pulse_q;

  logic            sat_eff;
  logic [W-1:0]    cnt_x;
  logic [W-1:0]    rv_x;
  logic [W-1:0]    step_x;
  logic [W-1:0]    sum_x;
  logic [W-1:0]    term_x;
  logic [W-1:0]    next_x;
  logic            wrap;
  logic [SIZE-1:0] count_next;
  logic            flag_next;

`ifdef FLEX_COUNTER_UD_SATURATE_EN
  assign sat_eff = bus.saturate;
`else
  // Port kept for interface compatibility; its value has no effect here.
  assign sat_eff = bus.saturate & 1'b0;
`endif

  always_comb begin
    cnt_x  = W'(count_q);
    rv_x   = (bus.rollover_val == '0) ? W'(1) : W'(bus.rollover_val);
    step_x = (bus.step == '0) ? W'(1) : W'(bus.step);
    sum_x  = cnt_x + step_x;
    next_x = cnt_x;
    wrap   = 1'b0;

    if (bus.clear) begin
      next_x = '0;
    end else if (bus.load) begin
      next_x = W'(bus.load_val);
    end else if (bus.count_enable) begin
      if (!bus.count_down) begin
        if (cnt_x >= rv_x) begin
          if (!sat_eff) begin
            next_x = W'(1);
            wrap   = 1'b1;
          end
        end else begin
          next_x = (sum_x > rv_x) ? rv_x : sum_x;
        end
      end else begin
        // A count of 0 (just cleared) is treated like the bottom end and wraps to RV.
        if (cnt_x <= W'(1)) begin
          if (!sat_eff) begin
            next_x = rv_x;
            wrap   = 1'b1;
          end
        end else begin
          next_x = (cnt_x > step_x) ? (cnt_x - step_x) : W'(1);
        end
      end
    end

    // Terminal value follows the direction applied in this same cycle.
    term_x     = bus.count_down ? W'(1) : rv_x;
    flag_next  = (next_x == term_x);
    count_next = next_x[SIZE-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      flag_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      count_q <= count_next;
      flag_q  <= flag_next;
      pulse_q <= wrap;
    end
  end

  assign bus.count_out      = count_q;
  assign bus.rollover_flag  = flag_q;
  assign bus.rollover_pulse = pulse_q;

endmodule
